// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port memory
// with a registered read; each access is one issue cycle then one ack cycle.
`default_nettype none

module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wen0,
  input  logic                  wen1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q,  last_d;

  logic   w_any;
  logic   w_win;

  assign w_any = req0 | req1;
  // On a tie the port that was not granted last wins; otherwise the lone requester.
  assign w_win = (req0 & req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (w_any) begin
          state_d = S_RESP;
          owner_d = w_win;
          last_d  = w_win;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Outputs are gated by rst so they drop immediately, even mid-cycle.
  always_comb begin
    mem_wen     = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    rdata0      = '0;
    rdata1      = '0;
    if (!rst) begin
      if (state_q == S_IDLE) begin
        if (w_any) begin
          mem_wen     = w_win ? wen1   : wen0;
          mem_address = w_win ? addr1  : addr0;
          mem_data_in = w_win ? wdata1 : wdata0;
        end
      end else if (owner_q) begin
        ack1   = 1'b1;
        rdata1 = mem_data_out;
      end else begin
        ack0   = 1'b1;
        rdata0 = mem_data_out;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, scoreboard-checked bench for mem_arbiter with a
// behavioural registered write-first memory.
`default_nettype none

module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, wen0 = 1'b0, wen1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, mem_wen;
  logic [7:0] rdata0, rdata1, mem_address, mem_data_in;
  logic [7:0] mem_data_out = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic       port;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] bmem    [256];
  logic [7:0] ref_mem [256];

  mem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wen0(wen0), .wen1(wen1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_wen(mem_wen), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered, write-first single-port memory.
  always @(posedge clk) begin
    if (mem_wen) bmem[mem_address] <= mem_data_in;
    mem_data_out <= mem_wen ? mem_data_in : bmem[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic predict(input logic p, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input int at);
    exp_t e;
    if (w) ref_mem[a] = d;
    e.port = p;
    e.data = ref_mem[a];
    e.cyc  = at;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic p, input logic w, input logic [7:0] a, input logic [7:0] d);
    if (p) begin req1 = 1'b1; wen1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; wen0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic issue(input logic p, input logic w, input logic [7:0] a, input logic [7:0] d);
    predict(p, w, a, d, cyc + 1);
    drive(p, w, a, d);
  endtask

  task automatic wait_ack(input logic p);
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if ((p ? ack1 : ack0) === 1'b1) seen = 1'b1;
    end
    chk(p ? "ack1_timeout" : "ack0_timeout", 32'(seen), 32'd1);
    @(posedge clk); #1;
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic chk_mem(input string tag, input logic w, input logic [7:0] a, input logic [7:0] d);
    chk({tag, "_wen"},  32'(mem_wen),     32'(w));
    chk({tag, "_addr"}, 32'(mem_address), 32'(a));
    chk({tag, "_din"},  32'(mem_data_in), 32'(d));
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst) begin
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        chk("mem_wen_in_resp", 32'(mem_wen), 32'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_ack", 32'({ack1, ack0}), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("ack_port",  32'({ack1, ack0}), e.port ? 32'd2 : 32'd1);
          chk("ack_rdata", 32'(e.port ? rdata1 : rdata0), 32'(e.data));
          chk("ack_other_rdata", 32'(e.port ? rdata0 : rdata1), 32'd0);
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("rdata_no_ack", 32'({rdata1, rdata0}), 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      bmem[i]    = 8'h00;
      ref_mem[i] = 8'h00;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_acks", 32'({ack1, ack0}), 32'd0);
    chk_mem("rst", 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-port write then read back.
    issue(1'b0, 1'b1, 8'd184, 8'd12);
    @(negedge clk);
    chk_mem("wr184", 1'b1, 8'd184, 8'd12);
    wait_ack(1'b0);
    issue(1'b0, 1'b0, 8'd184, 8'h00);
    @(negedge clk);
    chk_mem("rd184", 1'b0, 8'd184, 8'h00);
    wait_ack(1'b0);

    // Reset in the middle of RESP: ack drops at once, the write stays in memory.
    drive(1'b0, 1'b1, 8'd7, 8'h55);
    @(posedge clk); #2;
    chk("pre_rst_ack0", 32'(ack0), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_acks", 32'({ack1, ack0}), 32'd0);
    chk_mem("midrst", 1'b0, 8'h00, 8'h00);
    ref_mem[7] = 8'h55;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Tie after reset: port 0 first, port 1 two cycles later.
    predict(1'b0, 1'b0, 8'd0, 8'h00, cyc + 1);
    predict(1'b1, 1'b1, 8'd0, 8'd34, cyc + 3);
    drive(1'b0, 1'b0, 8'd0, 8'h00);
    drive(1'b1, 1'b1, 8'd0, 8'd34);
    @(negedge clk);
    chk_mem("tie_p0", 1'b0, 8'd0, 8'h00);
    wait_ack(1'b0);
    @(negedge clk);
    chk_mem("tie_p1", 1'b1, 8'd0, 8'd34);
    wait_ack(1'b1);
    issue(1'b0, 1'b0, 8'd0, 8'h00);
    wait_ack(1'b0);
    issue(1'b1, 1'b0, 8'd7, 8'h00);
    wait_ack(1'b1);

    // Continuous contention: grants alternate 0,1,0,1.
    predict(1'b0, 1'b0, 8'd200, 8'h00, cyc + 1);
    predict(1'b1, 1'b1, 8'd200, 8'hA5, cyc + 3);
    predict(1'b0, 1'b0, 8'd200, 8'h00, cyc + 5);
    predict(1'b1, 1'b1, 8'd200, 8'hA5, cyc + 7);
    drive(1'b0, 1'b0, 8'd200, 8'h00);
    drive(1'b1, 1'b1, 8'd200, 8'hA5);
    repeat (8) @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;

    // Late request: req1 rises during port 0's RESP.
    issue(1'b0, 1'b0, 8'd184, 8'h00);
    @(posedge clk); #1;
    predict(1'b1, 1'b0, 8'd200, 8'h00, cyc + 2);
    drive(1'b1, 1'b0, 8'd200, 8'h00);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk_mem("late_p1", 1'b0, 8'd200, 8'h00);
    wait_ack(1'b1);

    // Idle hygiene.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_mem("idle", 1'b0, 8'h00, 8'h00);
      chk("idle_acks", 32'({ack1, ack0}), 32'd0);
    end

    // Still IDLE: a new request is issued in the same cycle; top address boundary.
    @(posedge clk); #1;
    issue(1'b1, 1'b1, 8'd255, 8'hFF);
    @(negedge clk);
    chk_mem("top_wr", 1'b1, 8'd255, 8'hFF);
    wait_ack(1'b1);
    issue(1'b0, 1'b0, 8'd255, 8'h00);
    wait_ack(1'b0);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
